// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one instruction-memory
// request at a time and hands fetched words to decode, honouring decode
// back-pressure (stall) and branch redirects (pc_sel_taken) with no delay slot.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | first cycle after reset; no request, inputs ignored
//   FETCH  | request outstanding at req_addr until imem_ack
//   HOLD   | captured instruction held for a stalled decode; no request
//
// kill marks an outstanding request whose data must be dropped because a
// redirect arrived before its ack; the request address is not changed
// mid-transaction, so the redirect target is fetched once the old ack lands.

module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        pc_sel_taken,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic        kill, kill_nxt;
  logic [31:0] instr_nxt, pc_out_nxt;
  logic        valid_nxt;
  logic        redirect;

  // Incrementer feeding the external next-PC mux; wraps naturally at 2^32.
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = req_addr;
  assign redirect  = pc_sel_taken & ~stall;

  // Next-state and datapath update decisions.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    kill_nxt     = kill;
    instr_nxt    = instr_out;
    pc_out_nxt   = pc_out;
    valid_nxt    = instr_valid;

    case (state)
      S_IDLE: begin
        state_nxt    = S_FETCH;
        req_addr_nxt = pc;
      end

      S_FETCH: begin
        if (imem_ack) begin
          if (kill) begin
            // Stale data from before a redirect: drop it and start on the new pc.
            kill_nxt  = 1'b0;
            valid_nxt = 1'b0;
            if (redirect) begin
              pc_nxt       = next_pc;
              req_addr_nxt = next_pc;
            end else begin
              req_addr_nxt = pc;
            end
          end else if (stall) begin
            instr_nxt  = imem_rdata;
            pc_out_nxt = req_addr;
            valid_nxt  = 1'b1;
            state_nxt  = S_HOLD;
          end else if (pc_sel_taken) begin
            valid_nxt    = 1'b0;
            pc_nxt       = next_pc;
            req_addr_nxt = next_pc;
          end else begin
            instr_nxt    = imem_rdata;
            pc_out_nxt   = req_addr;
            valid_nxt    = 1'b1;
            pc_nxt       = next_pc;
            req_addr_nxt = next_pc;
          end
        end else if (!stall) begin
          // No data this cycle: bubble. A redirect cannot cancel the bus
          // transaction, so remember to discard its data instead.
          valid_nxt = 1'b0;
          if (pc_sel_taken) begin
            pc_nxt   = next_pc;
            kill_nxt = 1'b1;
          end
        end
      end

      S_HOLD: begin
        // Decode takes the held word this cycle; what follows comes from
        // next_pc, which is either pc+4 or the redirect target.
        if (!stall) begin
          pc_nxt       = next_pc;
          req_addr_nxt = next_pc;
          valid_nxt    = 1'b0;
          state_nxt    = S_FETCH;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; imem_req is registered so it cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_VECTOR;
      req_addr    <= RESET_VECTOR;
      kill        <= 1'b0;
      instr_out   <= 32'h0;
      pc_out      <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      req_addr    <= req_addr_nxt;
      kill        <= kill_nxt;
      instr_out   <= instr_nxt;
      pc_out      <= pc_out_nxt;
      instr_valid <= valid_nxt;
      imem_req    <= (state_nxt == S_FETCH);
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: expected (pc, word) pairs are queued
// when an accepted ack is driven and compared when decode takes an instruction.

module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        pc_sel_taken;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_plus4;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] target;

  logic        imem_req1;
  logic [31:0] imem_addr1;
  logic [31:0] imem_rdata1;
  logic [31:0] pc_plus4_1;
  logic [31:0] pc_out1;
  logic [31:0] instr_out1;
  logic        instr_valid1;

  int          n_checks;
  int          n_errors;
  logic [63:0] sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0] ^ 16'h5A00};
  endfunction

  // Memory and the downstream next-PC mux around the unit.
  assign imem_rdata  = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  assign next_pc     = pc_sel_taken ? target : pc_plus4;
  assign imem_rdata1 = mem_word(imem_addr1);

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .pc_sel_taken(pc_sel_taken),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc_plus4(pc_plus4), .pc_out(pc_out),
    .instr_out(instr_out), .instr_valid(instr_valid)
  );

  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_rv (
    .clk(clk), .rst_n(rst_n), .next_pc(pc_plus4_1), .pc_sel_taken(1'b0),
    .stall(1'b0), .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ack(1'b1),
    .imem_rdata(imem_rdata1), .pc_plus4(pc_plus4_1), .pc_out(pc_out1),
    .instr_out(instr_out1), .instr_valid(instr_valid1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus. psh queues the word expected from an accepted ack
  // at paddr; a valid instruction taken by decode (no stall) is popped here.
  task automatic cyc(input logic ack, input logic stl, input logic tkn,
                     input logic [31:0] tgt, input logic psh, input logic [31:0] paddr);
    logic [63:0] e;
    imem_ack     = ack;
    stall        = stl;
    pc_sel_taken = tkn;
    target       = tgt;
    if (psh) begin
      chk("req_addr", imem_addr, paddr);
      chk("req_on", {31'b0, imem_req}, 32'd1);
      sb.push_back({paddr, mem_word(paddr)});
    end
    if (instr_valid && !stl) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("pc_out", pc_out, e[63:32]);
        chk("instr_out", instr_out, e[31:0]);
      end
    end
    step();
  endtask

  task automatic hold_reset();
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    stall        = 1'b0;
    pc_sel_taken = 1'b0;
    target       = 32'h0;
    repeat (2) step();
    sb.delete();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset values, latency, back-to-back fetch, wrapping reset vector.
    hold_reset();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_plus4", pc_plus4, 32'h4);
    chk("rv_plus4", pc_plus4_1, 32'h0);
    rst_n = 1'b1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    chk("rv_idle_req", {31'b0, imem_req1}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("lat_valid", {31'b0, instr_valid}, 32'd0);
    chk("rv_addr0", imem_addr1, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 1, 32'h0);
    chk("rv_addr1", imem_addr1, 32'h0);
    cyc(1, 0, 0, 0, 1, 32'h4);
    chk("b2b_valid4", {31'b0, instr_valid}, 32'd1);
    cyc(1, 0, 0, 0, 1, 32'h8);
    chk("b2b_valid8", {31'b0, instr_valid}, 32'd1);
    cyc(1, 0, 0, 0, 1, 32'hC);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sb_drain1", 32'(sb.size()), 32'd0);

    // Ack delayed three cycles at address 8.
    hold_reset();
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h0);
    cyc(1, 0, 0, 0, 1, 32'h4);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wait_addr2", imem_addr, 32'h8);
    chk("wait_valid2", {31'b0, instr_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wait_valid3", {31'b0, instr_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wait_valid4", {31'b0, instr_valid}, 32'd0);
    cyc(1, 0, 0, 0, 1, 32'h8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sb_drain2", 32'(sb.size()), 32'd0);

    // Stall on the ack of address 4 for two cycles.
    hold_reset();
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 32'h4);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_valid", {31'b0, instr_valid}, 32'd1);
    chk("hold_pc_out", pc_out, 32'h4);
    cyc(0, 1, 0, 0, 0, 0);
    chk("hold_pc_out2", pc_out, 32'h4);
    chk("hold_instr2", instr_out, mem_word(32'h4));
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sb_drain3", 32'(sb.size()), 32'd0);

    // Redirect to 0x100 while the request at 0xC is outstanding.
    hold_reset();
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h0);
    cyc(1, 0, 0, 0, 1, 32'h4);
    cyc(1, 0, 0, 0, 1, 32'h8);
    cyc(0, 0, 1, 32'h100, 0, 0);
    chk("kill_addr", imem_addr, 32'hC);
    chk("kill_valid", {31'b0, instr_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("kill_valid2", {31'b0, instr_valid}, 32'd0);
    cyc(1, 0, 0, 0, 1, 32'h100);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sb_drain4", 32'(sb.size()), 32'd0);

    // Redirect in the same cycle as an ack: acked data dropped.
    hold_reset();
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h0);
    cyc(1, 0, 1, 32'h200, 0, 0);
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    cyc(1, 0, 0, 0, 1, 32'h200);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sb_drain5", 32'(sb.size()), 32'd0);

    // Asynchronous reset with a redirect pending.
    hold_reset();
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 1, 32'h300, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_valid", {31'b0, instr_valid}, 32'd0);
    chk("arst_instr", instr_out, 32'h0);
    chk("arst_pc_out", pc_out, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("sb_drain6", 32'(sb.size()), 32'd0);
    hold_reset();
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sb_drain7", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 next_pc  input  32  selected next PC from the downstream 2:1 32-bit next-PC mux (pc_plus4 or branch target).
REQ-005 pc_sel_taken  input  1  select line of that mux; 1 = redirect to branch target.
REQ-006 stall  input  1  decode stage cannot accept an instruction this cycle.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 pc_plus4  output  32  PC + 4; drives mux input 0.
REQ-012 pc_out  output  32  address of instr_out.
REQ-013 instr_out  output  32  instruction presented to decode.
REQ-014 instr_valid  output  1  instr_out is a real instruction (0 = bubble).

Function
REQ-015 Internal pc register; pc_plus4 = pc + 4 combinational, wrapping mod 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-016 FSM states IDLE, FETCH, HOLD; plus one-bit kill flag.
REQ-017 IDLE: imem_req=0; unconditional transition to FETCH next cycle; all inputs ignored.
REQ-018 FETCH: imem_req=1; imem_addr from registered req_addr, loaded with pc on entry to FETCH and on every pc update, held stable until imem_ack.
REQ-019 FETCH, ack=1, stall=0, pc_sel_taken=0, kill=0: instr_out<=imem_rdata, pc_out<=req_addr, instr_valid<=1, pc<=next_pc, stay FETCH (back-to-back, one instruction per cycle at ack every cycle).
REQ-020 FETCH, ack=1, stall=1, kill=0: capture instr_out/pc_out, instr_valid<=1, pc unchanged, go HOLD.
REQ-021 FETCH, ack=1, kill=1: data discarded, instr_valid<=0, kill<=0, stay FETCH; pc not advanced.
REQ-022 FETCH, ack=0, stall=0: instr_valid<=0 (bubble); outstanding request unaffected.
REQ-023 Redirect = pc_sel_taken=1 and stall=0 in FETCH or HOLD: pc<=next_pc, instr_valid<=0; data acked same cycle discarded; no delay slot.
REQ-024 Redirect in FETCH with ack=0: kill<=1, req_addr held until ack, then reloaded with new pc.
REQ-025 Redirect in HOLD: go FETCH with new pc.
REQ-026 stall=1 has priority over pc_sel_taken; redirect ignored while stalled (source holds it).
REQ-027 HOLD: imem_req=0; instr_out/pc_out/instr_valid held; stall=0 and no redirect -> pc<=next_pc, go FETCH.
REQ-028 stall=1 in FETCH with ack=0: instr_valid and instr_out held; request continues.
REQ-029 Latency: first instr_valid no earlier than 2 cycles after rst_n deassertion (IDLE, then FETCH with ack).

Reset
REQ-030 rst_n=0 asynchronously forces: pc=RESET_VECTOR, req_addr=RESET_VECTOR, state=IDLE, kill=0, imem_req=0, instr_valid=0, instr_out=0, pc_out=0.
REQ-031 Reset mid-transaction abandons the request; pending ack after reset is ignored until FETCH re-entered.
REQ-032 Deassertion treated synchronously by FSM; no output glitch on release.

Verification
REQ-033 Reset release, ack every cycle, pc_sel_taken=0 -> imem_addr 0,4,8,12; pc_out follows one cycle later; instr_valid continuous.
REQ-034 Ack delayed 3 cycles at addr 8 -> imem_addr stays 8, instr_valid=0 three cycles, then pc_out=8 with imem_rdata.
REQ-035 stall=1 on ack of addr 4 for 2 cycles -> HOLD, instr_out/pc_out=4 held, imem_req=0; release -> fetch 8.
REQ-036 pc_sel_taken=1, next_pc=32'h100 while request at 0xC pending -> 0xC data discarded, next imem_addr=0x100, no valid for 0xC.
REQ-037 RESET_VECTOR=32'hFFFF_FFFC -> pc_plus4=0, second fetch at 0x0.
REQ-038 rst_n low during FETCH with redirect pending -> all outputs reset values immediately, kill cleared, fetch restarts at RESET_VECTOR.
